// File: rtl/pipelined_addsub.sv
// Pipelined N-bit adder/subtractor: the carry chain is cut into STAGES chunks of
// W bits, one chunk per cycle, behind a single global-enable valid/ready handshake.
module pipelined_addsub #(
  parameter int N      = 16,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sub,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         ovf
);
  localparam int W = N / STAGES;

  // Handshake: a beat moves on an edge where valid && ready. The whole pipe advances
  // together whenever the output slot is empty or being consumed; otherwise it holds.
  logic         adv;
  logic [N-1:0] bx;
  logic         c0;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv && !rst;
  assign bx       = sub ? ~b : b;
  assign c0       = sub ? 1'b1 : cin;

  if (STAGES == 1) begin : g_one
    logic [N:0] fs;
    assign fs = {1'b0, a} + {1'b0, bx} + {{N{1'b0}}, c0};

    always_ff @(posedge clk) begin
      if (rst) begin
        out_valid <= 1'b0;
        sum       <= '0;
        cout      <= 1'b0;
        ovf       <= 1'b0;
      end else if (adv) begin
        out_valid <= in_valid;
        sum       <= fs[N-1:0];
        cout      <= fs[N];
        ovf       <= (a[N-1] == bx[N-1]) && (fs[N-1] != a[N-1]);
      end
    end
  end else begin : g_pipe
    // Stage k finishes chunk k; rr holds finished low chunks, ra/rb the untouched high ones.
    for (genvar k = 0; k < STAGES - 1; k++) begin : g_st
      localparam int RW = (k + 1) * W;
      localparam int OW = N - RW;

      logic [W-1:0]  ca, cb;
      logic          ci, vi;
      logic [OW-1:0] na, nb;
      logic [RW-1:0] nr;
      logic [W:0]    s;
      logic [OW-1:0] ra, rb;
      logic [RW-1:0] rr;
      logic          rc, rv;

      if (k == 0) begin : g_in
        assign ca = a[W-1:0];
        assign cb = bx[W-1:0];
        assign ci = c0;
        assign vi = in_valid;
        assign na = a[N-1:W];
        assign nb = bx[N-1:W];
        assign nr = s[W-1:0];
      end else begin : g_chain
        assign ca = g_st[k-1].ra[W-1:0];
        assign cb = g_st[k-1].rb[W-1:0];
        assign ci = g_st[k-1].rc;
        assign vi = g_st[k-1].rv;
        assign na = g_st[k-1].ra[OW+W-1:W];
        assign nb = g_st[k-1].rb[OW+W-1:W];
        assign nr = {s[W-1:0], g_st[k-1].rr};
      end

      assign s = {1'b0, ca} + {1'b0, cb} + {{W{1'b0}}, ci};

      always_ff @(posedge clk) begin
        if (rst) begin
          rv <= 1'b0;
        end else if (adv) begin
          rv <= vi;
          ra <= na;
          rb <= nb;
          rr <= nr;
          rc <= s[W];
        end
      end
    end

    logic [W-1:0] fa, fb;
    logic [W:0]   fs;
    assign fa = g_st[STAGES-2].ra;
    assign fb = g_st[STAGES-2].rb;
    assign fs = {1'b0, fa} + {1'b0, fb} + {{W{1'b0}}, g_st[STAGES-2].rc};

    always_ff @(posedge clk) begin
      if (rst) begin
        out_valid <= 1'b0;
        sum       <= '0;
        cout      <= 1'b0;
        ovf       <= 1'b0;
      end else if (adv) begin
        out_valid <= g_st[STAGES-2].rv;
        sum       <= {fs[W-1:0], g_st[STAGES-2].rr};
        cout      <= fs[W];
        ovf       <= (fa[W-1] == fb[W-1]) && (fs[W-1] != fa[W-1]);
      end
    end
  end
endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub: d0 is N=4/STAGES=2, d1 is N=4/STAGES=1, d2 is N=8/STAGES=4.
module tb_pipelined_addsub;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] rst, in_valid, out_ready, sub, cin;
  wire  [2:0] in_ready, out_valid, cout, ovf;
  logic [7:0] a[3], b[3];
  wire  [3:0] s0, s1;
  wire  [7:0] s2;
  logic [7:0] sumv[3];
  assign sumv[0] = {4'h0, s0};
  assign sumv[1] = {4'h0, s1};
  assign sumv[2] = s2;

  pipelined_addsub #(.N(4), .STAGES(2)) u0 (
    .clk(clk), .rst(rst[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .a(a[0][3:0]), .b(b[0][3:0]), .sub(sub[0]), .cin(cin[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .sum(s0), .cout(cout[0]), .ovf(ovf[0]));
  pipelined_addsub #(.N(4), .STAGES(1)) u1 (
    .clk(clk), .rst(rst[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .a(a[1][3:0]), .b(b[1][3:0]), .sub(sub[1]), .cin(cin[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .sum(s1), .cout(cout[1]), .ovf(ovf[1]));
  pipelined_addsub #(.N(8), .STAGES(4)) u2 (
    .clk(clk), .rst(rst[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .a(a[2]), .b(b[2]), .sub(sub[2]), .cin(cin[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]), .sum(s2), .cout(cout[2]), .ovf(ovf[2]));

  int nn[3]  = '{4, 4, 8};
  int stg[3] = '{2, 1, 4};
  logic [9:0] exp_q[3][$];
  logic [9:0] held[3];
  bit   hold_chk[3];
  int   n_chk = 0, n_fail = 0;
  int   acc[3], dlv[3], drop[3];
  bit   done1 = 0, done2 = 0;

  // Reference: plain integer arithmetic; packs {ovf, cout, sum[7:0]}.
  function automatic logic [9:0] model(int n, int av, int bv, bit s, bit c);
    int m    = (1 << n) - 1;
    int half = 1 << (n - 1);
    int res, sa, sb, sr;
    bit co, o;
    if (s) begin
      res = (av - bv) & m;
      co  = (av >= bv);
    end else begin
      res = (av + bv + c) & m;
      co  = (av + bv + c) > m;
    end
    sa = (av >= half) ? av - (1 << n) : av;
    sb = (bv >= half) ? bv - (1 << n) : bv;
    sr = s ? sa - sb : sa + sb + c;
    o  = (sr > half - 1) || (sr < -half);
    return {o, co, 8'(res)};
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  // Scoreboard: every cycle, compare the presented result with the oldest expected beat.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      logic [9:0] got;
      got = {ovf[i], cout[i], sumv[i]};
      if (hold_chk[i]) begin
        chk($sformatf("d%0d_hold_data", i), 32'(got), 32'(held[i]));
        chk($sformatf("d%0d_hold_valid", i), 32'(out_valid[i]), 1);
      end
      if (out_valid[i]) begin
        if (exp_q[i].size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL d%0d_spurious: got out_valid=1 sum=%0d expected no result", i, sumv[i]);
        end else begin
          chk($sformatf("d%0d_result", i), 32'(got), 32'(exp_q[i][0]));
          if (out_ready[i]) begin
            void'(exp_q[i].pop_front());
            dlv[i]++;
          end
        end
      end
      hold_chk[i] = out_valid[i] && !out_ready[i] && !rst[i];
      held[i]     = got;
      if (rst[i]) begin
        drop[i] += exp_q[i].size();
        exp_q[i].delete();
      end else if (in_valid[i] && in_ready[i]) begin
        exp_q[i].push_back(model(nn[i], int'(a[i]), int'(b[i]), sub[i], cin[i]));
        acc[i]++;
      end
    end
  end

  // Present one beat and return just after the edge that accepted it.
  task automatic beat(input int i, input logic [7:0] av, input logic [7:0] bv,
                      input bit s, input bit c);
    bit ok;
    int n;
    a[i] = av; b[i] = bv; sub[i] = s; cin[i] = c; in_valid[i] = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      ok = in_ready[i];
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 200);
    if (!ok) chk($sformatf("d%0d_accept_timeout", i), 0, 1);
  endtask

  task automatic expect_res(input string nm, input int i, input logic [7:0] es,
                            input bit ec, input bit eo);
    in_valid[i] = 1'b0;
    if (stg[i] > 1) chk({nm, "_early"}, 32'(out_valid[i]), 0);
    for (int k = 1; k < stg[i]; k++) begin
      @(posedge clk);
      #1;
    end
    chk({nm, "_valid"}, 32'(out_valid[i]), 1);
    chk({nm, "_sum"}, 32'(sumv[i]), 32'(es));
    chk({nm, "_cout"}, 32'(cout[i]), 32'(ec));
    chk({nm, "_ovf"}, 32'(ovf[i]), 32'(eo));
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] blist[16] = '{0, 1, 2, 3, 15, 16, 85, 100, 126, 127, 128, 129, 170, 200, 254, 255};
  logic [7:0] tp_a[4]   = '{1, 3, 5, 7};
  logic [7:0] tp_b[4]   = '{2, 4, 6, 7};
  logic [7:0] tp_s[4]   = '{3, 7, 11, 14};

  initial begin
    rst = '1; in_valid = '0; out_ready = '1; sub = '0; cin = '0;
    for (int i = 0; i < 3; i++) begin
      a[i] = 0; b[i] = 0; acc[i] = 0; dlv[i] = 0; drop[i] = 0;
    end
    cyc(); cyc();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("d%0d_rst_out_valid", i), 32'(out_valid[i]), 0);
      chk($sformatf("d%0d_rst_sum", i), 32'(sumv[i]), 0);
      chk($sformatf("d%0d_rst_in_ready", i), 32'(in_ready[i]), 0);
    end
    rst = '0;
    #1;
    for (int i = 0; i < 3; i++) chk($sformatf("d%0d_in_ready_after_rst", i), 32'(in_ready[i]), 1);

    beat(0, 1, 1, 0, 0);  expect_res("t1_add", 0, 2, 0, 0);
    beat(0, 15, 1, 0, 0); expect_res("t2_wrap", 0, 0, 1, 0);
    beat(0, 7, 1, 0, 0);  expect_res("t2_ovf", 0, 8, 0, 1);
    beat(0, 3, 5, 1, 1);  expect_res("t3_borrow", 0, 14, 0, 0);
    beat(0, 8, 1, 1, 0);  expect_res("t3_subovf", 0, 7, 1, 1);
    beat(1, 15, 1, 0, 0); expect_res("s1_wrap", 1, 0, 1, 0);
    beat(1, 8, 1, 1, 0);  expect_res("s1_subovf", 1, 7, 1, 1);
    beat(1, 7, 0, 0, 1);  expect_res("s1_cin", 1, 8, 0, 1);
    in_valid[1] = 1'b0;
    cyc();

    // Four back-to-back beats; results must land on four consecutive cycles.
    for (int k = 0; k < 7; k++) begin
      if (k < 4) begin
        a[0] = tp_a[k]; b[0] = tp_b[k]; sub[0] = 0; cin[0] = 0; in_valid[0] = 1;
        chk("t4_in_ready", 32'(in_ready[0]), 1);
      end else begin
        in_valid[0] = 0;
      end
      if (k >= 2 && k < 6) begin
        chk("t4_valid", 32'(out_valid[0]), 1);
        chk("t4_sum", 32'(sumv[0]), 32'(tp_s[k-2]));
      end else begin
        chk("t4_gap", 32'(out_valid[0]), 0);
      end
      cyc();
    end

    fork
      begin
        beat(0, 2, 3, 0, 0);
        beat(0, 9, 4, 1, 0);
        beat(0, 4, 4, 0, 1);
        beat(0, 6, 9, 1, 0);
        beat(0, 12, 12, 0, 0);
        in_valid[0] = 0;
      end
      begin
        out_ready[0] = 0;
        cyc(); cyc();
        for (int k = 0; k < 3; k++) begin
          chk("t5_in_ready", 32'(in_ready[0]), 0);
          chk("t5_valid", 32'(out_valid[0]), 1);
          chk("t5_sum", 32'(sumv[0]), 5);
          cyc();
        end
        out_ready[0] = 1;
      end
    join
    repeat (6) cyc();

    out_ready[0] = 0;
    beat(0, 5, 5, 0, 0);
    beat(0, 6, 6, 0, 0);
    in_valid[0] = 0;
    rst[0] = 1;
    #1;
    chk("t6_in_ready_in_rst", 32'(in_ready[0]), 0);
    cyc();
    rst[0] = 0;
    #1;
    chk("t6_valid", 32'(out_valid[0]), 0);
    chk("t6_sum", 32'(sumv[0]), 0);
    chk("t6_cout", 32'(cout[0]), 0);
    chk("t6_ovf", 32'(ovf[0]), 0);
    chk("t6_in_ready", 32'(in_ready[0]), 1);
    out_ready[0] = 1;
    for (int k = 0; k < 5; k++) begin
      chk("t6_no_stale", 32'(out_valid[0]), 0);
      cyc();
    end
    beat(0, 2, 2, 0, 0); expect_res("t6_recover", 0, 4, 0, 0);
    in_valid[0] = 0;

    fork
      begin
        for (int x = 0; x < 256; x++)
          for (int j = 0; j < 16; j++)
            for (int s = 0; s < 2; s++)
              beat(2, 8'(x), blist[j], s[0], bit'((x + j) & 1));
        in_valid[2] = 0;
        done2 = 1;
      end
      begin
        while (!done2) begin
          out_ready[2] = ($urandom_range(0, 3) != 0);
          cyc();
        end
        out_ready[2] = 1;
      end
      begin
        for (int k = 0; k < 60; k++)
          beat(1, 8'($urandom_range(0, 15)), 8'($urandom_range(0, 15)),
               bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
        in_valid[1] = 0;
        done1 = 1;
      end
      begin
        while (!done1) begin
          out_ready[1] = ($urandom_range(0, 1) != 0);
          cyc();
        end
        out_ready[1] = 1;
      end
    join
    repeat (12) cyc();

    for (int i = 0; i < 3; i++) begin
      chk($sformatf("d%0d_drained", i), 32'(exp_q[i].size()), 0);
      chk($sformatf("d%0d_delivered", i), 32'(dlv[i] + drop[i]), 32'(acc[i]));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got no end of test expected completion");
    $fatal(1, "watchdog");
  end
endmodule
